// File: rtl/regfile_dp.sv
// Dual-read, single-write register file with registered reads, write-first bypass,
// address range checking and a one-entry-per-cycle clear sweep.
module regfile_dp #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    output logic              busy,
    output logic              clr_done,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd0_en,
    input  logic [ADDR_W-1:0] rd0_addr,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd0_vld,
    input  logic              rd1_en,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic [DATA_W-1:0] rd1_data,
    output logic              rd1_vld,
    output logic              addr_err
);

    typedef enum logic {IDLE, CLEAR} state_t;

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in, rd0_in, rd1_in;
    logic              wr_ok, rd0_ok, rd1_ok, err_nxt;
    logic [DATA_W-1:0] rd0_nxt, rd1_nxt;

    // A power-of-two depth covers the whole address space, so no range compare is needed
    generate
        if ((1 << ADDR_W) == DEPTH) begin : g_full
            assign wr_in  = 1'b1;
            assign rd0_in = 1'b1;
            assign rd1_in = 1'b1;
        end else begin : g_part
            localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(DEPTH);
            assign wr_in  = (wr_addr  < LIMIT);
            assign rd0_in = (rd0_addr < LIMIT);
            assign rd1_in = (rd1_addr < LIMIT);
        end
    endgenerate

    assign wr_ok   = wr_en  & ~busy & wr_in;
    assign rd0_ok  = rd0_en & ~busy;
    assign rd1_ok  = rd1_en & ~busy;
    assign err_nxt = ~busy & ((wr_en & ~wr_in) | (rd0_en & ~rd0_in) | (rd1_en & ~rd1_in));

    always_comb begin
        rd0_nxt = '0;
        rd1_nxt = '0;
        if (wr_ok && (wr_addr == rd0_addr)) begin
            rd0_nxt = wr_data;
        end else if (rd0_in) begin
            rd0_nxt = mem[rd0_addr];
        end
        if (wr_ok && (wr_addr == rd1_addr)) begin
            rd1_nxt = wr_data;
        end else if (rd1_in) begin
            rd1_nxt = mem[rd1_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            clr_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        busy  <= 1'b1;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    if (cnt == LAST) begin
                        state    <= IDLE;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The sweep owns the array while busy; host writes are only taken in IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (state == CLEAR) begin
            mem[cnt] <= '0;
        end else if (wr_ok) begin
            mem[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd0_data <= '0;
            rd1_data <= '0;
            rd0_vld  <= 1'b0;
            rd1_vld  <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            rd0_vld  <= rd0_ok;
            rd1_vld  <= rd1_ok;
            addr_err <= err_nxt;
            if (rd0_ok) begin
                rd0_data <= rd0_nxt;
            end
            if (rd1_ok) begin
                rd1_data <= rd1_nxt;
            end
        end
    end

endmodule

// File: tb/tb_regfile_dp.sv
// Directed and scoreboard-checked bench for regfile_dp; a second DEPTH=12 instance
// covers out-of-range addressing.
module tb_regfile_dp;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rd0_en, rd1_en;
    logic [3:0]  rd0_addr, rd1_addr;

    logic        busy, clr_done, rd0_vld, rd1_vld, addr_err;
    logic [31:0] rd0_data, rd1_data;
    logic        busy12, clr_done12, rd0_vld12, rd1_vld12, addr_err12;
    logic [31:0] rd0_data12, rd1_data12;

    logic [31:0] model [16];
    int          checks = 0;
    int          passes = 0;

    always #5 clk = ~clk;

    regfile_dp #(.DATA_W(32), .DEPTH(16)) dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy), .clr_done(clr_done),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data), .rd0_vld(rd0_vld),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data), .rd1_vld(rd1_vld),
        .addr_err(addr_err)
    );

    regfile_dp #(.DATA_W(32), .DEPTH(12)) dut12 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .busy(busy12), .clr_done(clr_done12),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd0_en(rd0_en), .rd0_addr(rd0_addr), .rd0_data(rd0_data12), .rd0_vld(rd0_vld12),
        .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data12), .rd1_vld(rd1_vld12),
        .addr_err(addr_err12)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        clr = 0; wr_en = 0; wr_addr = 0; wr_data = 0;
        rd0_en = 0; rd0_addr = 0; rd1_en = 0; rd1_addr = 0;
    endtask

    task automatic fill(input logic [31:0] base);
        for (int i = 0; i < 16; i++) begin
            wr_en = 1; wr_addr = 4'(i); wr_data = base + 32'(i);
            tick();
            model[i] = base + 32'(i);
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        tick();
        tick();
        checks++;
        if ({rd0_vld, rd1_vld, busy, clr_done, addr_err} !== 5'b0)
            $display("[TB] FAIL reset_flags got=%b exp=00000", {rd0_vld, rd1_vld, busy, clr_done, addr_err});
        else passes++;
        checks++;
        if ({rd0_data, rd1_data} !== 64'h0)
            $display("[TB] FAIL reset_data got=%h exp=0", {rd0_data, rd1_data});
        else passes++;
        rst_n = 1;
        tick();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic test_fill_read();
        fill(32'hA5A5_0001);
        for (int i = 0; i < 8; i++) begin
            rd0_en = 1; rd0_addr = 4'(2 * i);
            rd1_en = 1; rd1_addr = 4'(2 * i + 1);
            tick();
            checks++;
            if (rd0_data !== 32'hA5A5_0001 + 32'(2 * i) || rd0_vld !== 1'b1)
                $display("[TB] FAIL fill_rd0[%0d] got=%h/%b exp=%h/1", 2 * i, rd0_data, rd0_vld, 32'hA5A5_0001 + 32'(2 * i));
            else passes++;
            checks++;
            if (rd1_data !== 32'hA5A5_0002 + 32'(2 * i) || rd1_vld !== 1'b1)
                $display("[TB] FAIL fill_rd1[%0d] got=%h/%b exp=%h/1", 2 * i + 1, rd1_data, rd1_vld, 32'hA5A5_0002 + 32'(2 * i));
            else passes++;
        end
        idle_inputs();
        tick();
        checks++;
        if ({rd0_vld, rd1_vld} !== 2'b00 || rd0_data !== 32'hA5A5_000F || rd1_data !== 32'hA5A5_0010)
            $display("[TB] FAIL read_hold got=%b %h %h exp=00 a5a5000f a5a50010", {rd0_vld, rd1_vld}, rd0_data, rd1_data);
        else passes++;
    endtask

    task automatic test_bypass();
        wr_en = 1; wr_addr = 5; wr_data = 32'hDEAD_BEEF;
        rd0_en = 1; rd0_addr = 5; rd1_en = 1; rd1_addr = 6;
        tick();
        model[5] = 32'hDEAD_BEEF;
        checks++;
        if (rd0_data !== 32'hDEAD_BEEF)
            $display("[TB] FAIL bypass_rd0 got=%h exp=deadbeef", rd0_data);
        else passes++;
        checks++;
        if (rd1_data !== 32'hA5A5_0007)
            $display("[TB] FAIL bypass_rd1_old got=%h exp=a5a50007", rd1_data);
        else passes++;
        idle_inputs();
        rd0_en = 1; rd0_addr = 9; rd1_en = 1; rd1_addr = 9;
        tick();
        checks++;
        if (rd0_data !== 32'hA5A5_000A || rd1_data !== 32'hA5A5_000A)
            $display("[TB] FAIL same_addr got=%h %h exp=a5a5000a", rd0_data, rd1_data);
        else passes++;
        rd0_addr = 5; rd1_en = 0;
        tick();
        checks++;
        if (rd0_data !== 32'hDEAD_BEEF)
            $display("[TB] FAIL write_visible got=%h exp=deadbeef", rd0_data);
        else passes++;
        idle_inputs();
    endtask

    task automatic test_addr_err();
        wr_en = 1; wr_addr = 13; wr_data = 32'h0BAD_0BAD;
        rd1_en = 1; rd1_addr = 14;
        tick();
        model[13] = 32'h0BAD_0BAD;
        checks++;
        if (addr_err12 !== 1'b1 || rd1_data12 !== 32'h0 || rd1_vld12 !== 1'b1)
            $display("[TB] FAIL oor_first got=%b %h %b exp=1 0 1", addr_err12, rd1_data12, rd1_vld12);
        else passes++;
        checks++;
        if (addr_err !== 1'b0)
            $display("[TB] FAIL oor_depth16 got=%b exp=0", addr_err);
        else passes++;
        idle_inputs();
        rd0_en = 1; rd0_addr = 1;
        tick();
        checks++;
        if (addr_err12 !== 1'b0 || rd0_data12 !== 32'hA5A5_0002)
            $display("[TB] FAIL oor_after got=%b %h exp=0 a5a50002", addr_err12, rd0_data12);
        else passes++;
        wr_en = 1; wr_addr = 15; wr_data = 32'h1111_2222;
        rd0_en = 1; rd0_addr = 12; rd1_en = 1; rd1_addr = 13;
        tick();
        model[15] = 32'h1111_2222;
        idle_inputs();
        checks++;
        if (addr_err12 !== 1'b1)
            $display("[TB] FAIL oor_multi got=%b exp=1", addr_err12);
        else passes++;
        tick();
        checks++;
        if (addr_err12 !== 1'b0)
            $display("[TB] FAIL oor_single_pulse got=%b exp=0", addr_err12);
        else passes++;
    endtask

    task automatic test_clear();
        int busy_cycles;
        int vld_seen;
        int done_seen;
        fill(32'hA5A5_0100);
        clr = 1; wr_en = 1; wr_addr = 3; wr_data = 32'h1234_5678;
        rd0_en = 1; rd0_addr = 2; rd1_en = 1; rd1_addr = 3;
        tick();
        checks++;
        if (busy !== 1'b1 || rd0_data !== 32'hA5A5_0102 || rd1_data !== 32'h1234_5678)
            $display("[TB] FAIL clr_req_cycle got=%b %h %h exp=1 a5a50102 12345678", busy, rd0_data, rd1_data);
        else passes++;
        busy_cycles = 1; vld_seen = 0; done_seen = 0;
        clr = 0; wr_en = 1; wr_addr = 0; wr_data = 32'h55;
        rd0_addr = 7; rd1_addr = 8;
        for (int c = 0; c < 40; c++) begin
            clr = (c == 4);
            tick();
            if (busy) busy_cycles++;
            if (rd0_vld || rd1_vld) vld_seen++;
            if (clr_done) begin
                done_seen = 1;
                idle_inputs();
                break;
            end
        end
        idle_inputs();
        checks++;
        if (done_seen != 1 || busy_cycles != 16 || busy !== 1'b0)
            $display("[TB] FAIL clr_timing got done=%0d busy_cycles=%0d busy=%b exp 1 16 0", done_seen, busy_cycles, busy);
        else passes++;
        checks++;
        if (vld_seen != 0 || rd0_data !== 32'hA5A5_0102 || rd1_data !== 32'h1234_5678)
            $display("[TB] FAIL busy_drop got vld=%0d %h %h exp 0 a5a50102 12345678", vld_seen, rd0_data, rd1_data);
        else passes++;
        tick();
        checks++;
        if (busy !== 1'b0 || clr_done !== 1'b0)
            $display("[TB] FAIL clr_no_queue got=%b%b exp=00", busy, clr_done);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            rd0_en = 1; rd0_addr = 4'(2 * i); rd1_en = 1; rd1_addr = 4'(2 * i + 1);
            tick();
            checks++;
            if (rd0_data !== 32'h0 || rd1_data !== 32'h0)
                $display("[TB] FAIL cleared[%0d] got=%h %h exp=0", 2 * i, rd0_data, rd1_data);
            else passes++;
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic test_reset_mid_sweep();
        int done_seen;
        fill(32'hA5A5_0200);
        rd0_en = 1; rd0_addr = 4;
        tick();
        idle_inputs();
        clr = 1;
        tick();
        clr = 0;
        repeat (6) tick();
        #2 rst_n = 0;
        #1;
        checks++;
        if ({busy, clr_done, rd0_vld, rd1_vld, addr_err} !== 5'b0 || {rd0_data, rd1_data} !== 64'h0)
            $display("[TB] FAIL midsweep_reset got=%b %h %h exp=0", {busy, clr_done, rd0_vld, rd1_vld, addr_err}, rd0_data, rd1_data);
        else passes++;
        tick();
        rst_n = 1;
        done_seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (clr_done || busy) done_seen++;
        end
        checks++;
        if (done_seen != 0)
            $display("[TB] FAIL midsweep_no_done got=%0d exp=0", done_seen);
        else passes++;
        for (int i = 0; i < 8; i++) begin
            rd0_en = 1; rd0_addr = 4'(2 * i); rd1_en = 1; rd1_addr = 4'(2 * i + 1);
            tick();
            checks++;
            if (rd0_data !== 32'h0 || rd1_data !== 32'h0)
                $display("[TB] FAIL midsweep_zero[%0d] got=%h %h exp=0", 2 * i, rd0_data, rd1_data);
            else passes++;
        end
        idle_inputs();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
    endtask

    task automatic test_random();
        logic        m_busy;
        int          m_cnt;
        logic        e_done, e_vld0, e_vld1, wr_acc;
        logic [31:0] e_rd0, e_rd1;
        int          hits;
        idle_inputs();
        rst_n = 0;
        tick();
        rst_n = 1;
        tick();
        for (int i = 0; i < 16; i++) model[i] = 32'h0;
        m_busy = 0; m_cnt = 0; e_rd0 = 0; e_rd1 = 0; hits = 0;
        for (int n = 0; n < 10000; n++) begin
            clr      = ($urandom_range(0, 299) == 0);
            wr_en    = $urandom_range(0, 1) == 1;
            wr_addr  = 4'($urandom_range(0, 15));
            wr_data  = $urandom;
            rd0_en   = $urandom_range(0, 3) != 0;
            rd0_addr = 4'($urandom_range(0, 15));
            rd1_en   = $urandom_range(0, 3) != 0;
            rd1_addr = 4'($urandom_range(0, 15));
            wr_acc = !m_busy && wr_en;
            e_vld0 = !m_busy && rd0_en;
            e_vld1 = !m_busy && rd1_en;
            if (e_vld0) begin
                e_rd0 = (wr_acc && wr_addr == rd0_addr) ? wr_data : model[rd0_addr];
                if (wr_acc && wr_addr == rd0_addr) hits++;
            end
            if (e_vld1) begin
                e_rd1 = (wr_acc && wr_addr == rd1_addr) ? wr_data : model[rd1_addr];
                if (wr_acc && wr_addr == rd1_addr) hits++;
            end
            e_done = 0;
            if (m_busy) begin
                model[m_cnt] = 32'h0;
                if (m_cnt == 15) begin
                    m_busy = 0;
                    e_done = 1;
                end else begin
                    m_cnt++;
                end
            end else begin
                if (wr_acc) model[wr_addr] = wr_data;
                if (clr) begin
                    m_busy = 1;
                    m_cnt = 0;
                end
            end
            tick();
            checks++;
            if ({busy, clr_done, addr_err, rd0_vld, rd1_vld, rd0_data, rd1_data} !==
                {m_busy, e_done, 1'b0, e_vld0, e_vld1, e_rd0, e_rd1})
                $display("[TB] FAIL random[%0d] got=%b%b%b%b%b %h %h exp=%b%b0%b%b %h %h", n,
                         busy, clr_done, addr_err, rd0_vld, rd1_vld, rd0_data, rd1_data,
                         m_busy, e_done, e_vld0, e_vld1, e_rd0, e_rd1);
            else passes++;
        end
        idle_inputs();
        checks++;
        if (hits == 0)
            $display("[TB] FAIL random_bypass_hits got=0 exp>0");
        else passes++;
    endtask

    initial begin
        rst_n = 0;
        idle_inputs();
        test_reset();
        test_fill_read();
        test_bypass();
        test_addr_err();
        test_clear();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/regfile_dp.md
# regfile_dp

Parametrised one-write/two-read register file with a 1-cycle registered read, write-to-read bypass, per-port read-valid strobes, address range checking and a sequential clear engine. It replaces the single-port divider register file in the OMP datapath, so the divider can read two operands per cycle while the update stage writes results back. The clear engine wipes the array between OMP iterations without a global reset.

## Interface
- DATA_W, 32, data width of every entry and port
- DEPTH, 16, number of entries, 2..1024, need not be a power of two
- ADDR_W, $clog2(DEPTH) (local, derived), address width

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  request a full-array clear, sampled only when busy=0
- busy  out  1  clear sweep in progress
- clr_done  out  1  one-cycle pulse, sweep complete
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- rd0_en, rd1_en  in  1  read request, port 0 and port 1
- rd0_addr, rd1_addr  in  ADDR_W  read address
- rd0_data, rd1_data  out  DATA_W  registered read data, held between reads
- rd0_vld, rd1_vld  out  1  one-cycle pulse, rdX_data updated this cycle
- addr_err  out  1  one-cycle pulse, an accepted request had an address ≥ DEPTH

## Operation
- Reset (rst_n=0, asynchronous): all entries are 0. rd0_data, rd1_data, rdX_vld, busy, clr_done and addr_err are 0. The state is IDLE and the sweep counter is 0.
- States are IDLE and CLEAR. busy=1 exactly while the state is CLEAR.
- IDLE → CLEAR: clr=1 at an edge while in IDLE. The counter loads 0.
- CLEAR: at each edge, entry[counter] ← 0 and the counter increments. After the edge that writes entry DEPTH-1, the state returns to IDLE and clr_done is 1 for that one cycle.
- clr while busy=1 is ignored; it does not queue.
- Accepted write: wr_en=1, busy=0 and wr_addr<DEPTH. The entry updates at the edge.
- Accepted read on port X: rdX_en=1 and busy=0.
  - rdX_data ← entry[rdX_addr], or ← 0 if rdX_addr ≥ DEPTH.
  - rdX_vld=1 in the following cycle.
- Bypass: if a write is accepted in the same cycle and wr_addr==rdX_addr, rdX_data ← wr_data (new data, write-first).
- Both ports may read the same address in the same cycle; both return identical data.
- Requests while busy=1 are dropped: no memory change, rdX_data holds, and no vld or err pulse is generated.
- Clear-request cycle (clr=1, busy=0): the write and reads in that cycle are serviced normally. Any written entry is then zeroed by the sweep.
- Out of range: a write or read with address ≥ DEPTH, with en=1 and busy=0, pulses addr_err in the next cycle. An out-of-range write is discarded. Multiple such requests in one cycle produce a single pulse.
- rdX_en=0: rdX_data holds its last value.

## Timing
- Write → memory: visible to a read issued in the next cycle. With the bypass it is also visible to a read issued in the same cycle.
- Read latency: 1 cycle. The address is sampled at edge N; data and vld are valid in cycle N+1.
- Clear: clr sampled at edge N.
  - busy=1 in cycles N+1 .. N+DEPTH.
  - clr_done=1 and busy=0 in cycle N+DEPTH+1.
  - New requests are accepted at edge N+DEPTH+1.
- Back-to-back operation: one write plus two reads per cycle, sustained, with no bubbles.
- Reset asserted mid-sweep: the block goes to IDLE immediately and every entry reads 0. No clr_done pulse is generated.
- All outputs are registered; there is no combinational path from any input to any output.

## Test plan
- Reset, then write 0xA5A5_0001..0xA5A5_0010 to addresses 0..15. Read them back two per cycle (ports 0 and 1) → each value appears 1 cycle after its request, with rdX_vld=1.
- Same-cycle write 0xDEAD_BEEF to addr 5 with rd0_addr=5 and rd1_addr=6 → rd0_data=0xDEAD_BEEF, rd1_data=the old entry 6.
- With DEPTH=12: write addr 13 and read addr 14 on port 1 → addr_err is a single pulse, rd1_data=0, rd1_vld=1, and a read of addr 1 is unchanged.
- Fill the array, pulse clr (also writing addr 3 in that cycle), and issue reads during busy.
  - busy is high for 16 cycles, then clr_done pulses.
  - No rdX_vld pulses occur during busy.
  - Afterwards all addresses read 0, including addr 3.
- Assert rst_n=0 at sweep cycle 7 with non-zero data present → outputs are 0 immediately, busy=0, no clr_done, and all entries read 0 after rst_n rises.
- Random mix of 10k writes and dual reads plus occasional clr, checked against a scoreboard model → zero mismatches, including bypass hits.
